// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage FP32 -> signed int32 converter with valid/ready.
// Ports: clk, rst (sync, active-high); x, mode, in_valid -> in_ready;
//        y, flags {invalid, inexact}, out_valid <- out_ready.
module ftoi_pipe #(
  parameter int FTZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic [1:0]  flags,
  output logic        out_valid,
  input  logic        out_ready
);

  if (FTZ != 1) begin : g_ftz_chk
    $error("ftoi_pipe: FTZ=0 is not supported");
  end

  typedef enum logic [1:0] {
    C_NUM,
    C_ZERO,
    C_NAN,
    C_OVF
  } cls_t;

  // handshake
  logic w_adv1;
  logic w_adv2;
  logic r_v1;
  logic r_v2;

  assign w_adv2    = ~r_v2 | out_ready;
  assign w_adv1    = ~r_v1 | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_v2;

  // stage 1: decode / align
  logic        w_s;
  logic [7:0]  w_e;
  logic [22:0] w_f;
  logic [23:0] w_sig;
  logic [7:0]  w_rsh;
  logic [3:0]  w_lsh;
  logic [47:0] w_ext;
  logic [31:0] w_big;
  logic        w_minint;
  logic        w_is_nan;
  logic        w_is_ovf;
  logic        w_is_zero;
  logic        w_is_frac;
  logic        w_is_mid;
  logic        w_is_big;

  cls_t        w_cls;
  logic [31:0] w_imag;
  logic        w_g;
  logic        w_st;

  assign w_s   = x[31];
  assign w_e   = x[30:23];
  assign w_f   = x[22:0];
  assign w_sig = {1'b1, w_f};

  // 127..149: right shift by 1..23, keeping shifted-out bits
  assign w_rsh = 8'd150 - w_e;
  assign w_ext = {w_sig, 24'b0} >> w_rsh;

  // 150..158: left shift by 0..8
  assign w_lsh = 4'(w_e - 8'd150);
  assign w_big = {8'b0, w_sig} << w_lsh;

  // -2^31 is the one e=158 value that fits
  assign w_minint  = w_s & (w_e == 8'd158) & (w_f == 23'd0);
  assign w_is_nan  = (w_e == 8'd255) & (w_f != 23'd0);
  assign w_is_ovf  = (w_e >= 8'd158) & ~w_is_nan & ~w_minint;
  assign w_is_zero = (w_e == 8'd0);
  assign w_is_frac = (w_e != 8'd0) & (w_e < 8'd127);
  assign w_is_mid  = (w_e >= 8'd127) & (w_e < 8'd150);
  assign w_is_big  = ((w_e >= 8'd150) & (w_e < 8'd158)) | w_minint;

  always_comb begin
    w_cls  = C_NUM;
    w_imag = 32'd0;
    w_g    = 1'b0;
    w_st   = 1'b0;
    unique case (1'b1)
      w_is_nan:  w_cls = C_NAN;
      w_is_ovf:  w_cls = C_OVF;
      w_is_zero: w_cls = C_ZERO;
      w_is_frac: begin
        w_g  = (w_e == 8'd126);
        w_st = (w_e < 8'd126) | (w_f != 23'd0);
      end
      w_is_mid: begin
        w_imag = {8'b0, w_ext[47:24]};
        w_g    = w_ext[23];
        w_st   = |w_ext[22:0];
      end
      w_is_big:  w_imag = w_big;
      default:   w_cls = C_NUM;
    endcase
  end

  logic        r_s;
  cls_t        r_cls;
  logic [31:0] r_imag;
  logic        r_g;
  logic        r_st;
  logic [1:0]  r_mode;

  // stage 2: round / negate / saturate
  logic        w_inx;
  logic        w_inc;
  logic [32:0] w_mag;
  logic        w_ovf2;
  logic [31:0] w_neg;
  logic [31:0] w_y;
  logic [1:0]  w_fl;

  assign w_inx = r_g | r_st;

  always_comb begin
    w_inc = 1'b0;
    unique case (r_mode)
      2'd1:    w_inc = r_g & (r_st | r_imag[0]);
      2'd2:    w_inc = r_s & w_inx;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_mag  = {1'b0, r_imag} + {32'b0, w_inc};
  assign w_ovf2 = r_s ? (w_mag > 33'h0_8000_0000)
                      : (w_mag > 33'h0_7FFF_FFFF);
  assign w_neg  = -w_mag[31:0];

  always_comb begin
    w_y  = 32'd0;
    w_fl = 2'b00;
    unique case (1'b1)
      (r_cls == C_NAN): begin
        w_y  = 32'h7FFF_FFFF;
        w_fl = 2'b10;
      end
      (r_cls == C_OVF) | ((r_cls == C_NUM) & w_ovf2): begin
        w_y  = r_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_fl = 2'b10;
      end
      (r_cls == C_ZERO): begin
        w_y  = 32'd0;
        w_fl = 2'b00;
      end
      default: begin
        w_y  = r_s ? w_neg : w_mag[31:0];
        w_fl = {1'b0, w_inx};
      end
    endcase
  end

  logic [31:0] r_y;
  logic [1:0]  r_flags;

  assign y     = r_y;
  assign flags = r_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_s     <= 1'b0;
      r_cls   <= C_NUM;
      r_imag  <= 32'd0;
      r_g     <= 1'b0;
      r_st    <= 1'b0;
      r_mode  <= 2'd0;
      r_y     <= 32'd0;
      r_flags <= 2'b00;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (in_valid & w_adv1) begin
        r_s    <= w_s;
        r_cls  <= w_cls;
        r_imag <= w_imag;
        r_g    <= w_g;
        r_st   <= w_st;
        r_mode <= (mode == 2'd3) ? 2'd0 : mode;
      end
      if (w_adv2) r_v2 <= r_v1;
      if (r_v1 & w_adv2) begin
        r_y     <= w_y;
        r_flags <= w_fl;
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe: scoreboard bench for ftoi_pipe.
// Directed cases plus randomized operands against a real-arithmetic model.
module tb_ftoi_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic [1:0]  flags;
  logic        out_valid;
  logic        out_ready;

  ftoi_pipe #(.FTZ(1)) dut (
    .clk(clk),
    .rst(rst),
    .x(x),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y(y),
    .flags(flags),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] y;
    logic [1:0]  fl;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   chk_lat = 0;
  bit   rnd_rdy = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // reference: exact real arithmetic on the decoded value
  function automatic logic [33:0] model(input logic [31:0] v,
                                        input logic [1:0] m);
    logic [7:0]  e;
    logic [22:0] f;
    real         r;
    real         fl;
    real         q;
    longint      iv;
    e = v[30:23];
    f = v[22:0];
    if (e == 8'd255 && f != 0) return {2'b10, 32'h7FFF_FFFF};
    if (e == 8'd255)
      return v[31] ? {2'b10, 32'h8000_0000} : {2'b10, 32'h7FFF_FFFF};
    if (e == 8'd0) return 34'd0;
    r  = $bitstoreal({v[31], 11'(e) + 11'd896, f, 29'b0});
    fl = $floor(r);
    if (m == 2'd2) q = fl;
    else if (m == 2'd1) begin
      if (r - fl > 0.5) q = fl + 1.0;
      else if (r - fl < 0.5) q = fl;
      else q = ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
    end else q = (r < 0.0) ? $ceil(r) : fl;
    if (q > 2147483647.0) return {2'b10, 32'h7FFF_FFFF};
    if (q < -2147483648.0) return {2'b10, 32'h8000_0000};
    iv = longint'(q);
    return {1'b0, (fl != r), iv[31:0]};
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] sp [10];
    int          c;
    logic [31:0] r;
    sp = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0001,
           32'h0000_0000, 32'h8000_0000, 32'h4F00_0000, 32'hCF00_0000,
           32'hCF00_0001, 32'h4EFF_FFFF};
    c = $urandom_range(0, 9);
    r = $urandom;
    if (c < 6) r[30:23] = 8'($urandom_range(120, 160));
    else if (c == 6) begin
      r[30:23] = 8'($urandom_range(124, 152));
      r[22:0]  = r[22:0] & 23'h7F_0000;
    end else if (c == 7) r = sp[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic send(input logic [31:0] v, input logic [1:0] m,
                      input logic [33:0] ex);
    int   k;
    exp_t en;
    in_valid = 1;
    x = v;
    mode = m;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
    else begin
      en.y   = ex[31:0];
      en.fl  = ex[33:32];
      en.cyc = cyc;
      en.lat = chk_lat;
      sb.push_back(en);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  // monitor
  initial forever begin
    exp_t en;
    @(negedge clk);
    if (rst) sb.delete();
    else if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", y, 32'hxxxx_xxxx);
      else begin
        en = sb.pop_front();
        chk("y", y, en.y);
        chk("flags", {30'd0, flags}, {30'd0, en.fl});
        if (en.lat) chk("latency", cyc - en.cyc, 32'd2);
        else chk("latency_min", {31'd0, (cyc - en.cyc) >= 2}, 32'd1);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    rst = 1;
    in_valid = 0;
    x = 0;
    mode = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_y", y, 32'd0);
    chk("rst_flags", {30'd0, flags}, 32'd0);
    @(posedge clk);
    #1;

    // nearest-even stream
    chk_lat = 1;
    send(32'h4020_0000, 2'd1, {2'b01, 32'd2});
    send(32'h4060_0000, 2'd1, {2'b01, 32'd4});
    send(32'h3F00_0000, 2'd1, {2'b01, 32'd0});
    send(32'h3F40_0000, 2'd1, {2'b01, 32'd1});
    chk_lat = 0;

    send(32'hBFC0_0000, 2'd0, {2'b01, 32'hFFFF_FFFF});
    send(32'hBFC0_0000, 2'd2, {2'b01, 32'hFFFF_FFFE});
    send(32'hBFC0_0000, 2'd1, {2'b01, 32'hFFFF_FFFE});
    send(32'h4F00_0000, 2'd0, {2'b10, 32'h7FFF_FFFF});
    send(32'hCF00_0000, 2'd0, {2'b00, 32'h8000_0000});
    send(32'h7FC0_0000, 2'd0, {2'b10, 32'h7FFF_FFFF});
    send(32'h8000_0001, 2'd2, {2'b00, 32'h0000_0000});
    send(32'h4B7F_FFFF, 2'd0, {2'b00, 32'h00FF_FFFF});
    send(32'hC120_0000, 2'd0, {2'b00, 32'hFFFF_FFF6});
    send(32'hFF80_0000, 2'd3, {2'b10, 32'h8000_0000});
    send(32'h7F80_0000, 2'd1, {2'b10, 32'h7FFF_FFFF});
    send(32'hBF00_0000, 2'd2, {2'b01, 32'hFFFF_FFFF});
    repeat (4) @(posedge clk);
    #1;

    // backpressure
    out_ready = 0;
    fork
      begin
        send(32'h3F80_0000, 2'd0, {2'b00, 32'd1});
        send(32'h4000_0000, 2'd0, {2'b00, 32'd2});
        send(32'h4040_0000, 2'd0, {2'b00, 32'd3});
        send(32'h4080_0000, 2'd0, {2'b00, 32'd4});
        send(32'h40A0_0000, 2'd0, {2'b00, 32'd5});
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
          @(negedge clk);
          k++;
        end
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_hold_y", y, 32'd1);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_nogap", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // reset with both stages full
    out_ready = 0;
    send(32'h4110_0000, 2'd0, {2'b00, 32'd9});
    send(32'h4120_0000, 2'd0, {2'b00, 32'd10});
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // randomized traffic
    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] v;
      logic [1:0]  m;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        v = gen();
        m = 2'($urandom_range(0, 3));
        send(v, m, model(v, m));
      end
    end
    rnd_rdy = 0;
    out_ready = 1;

    begin
      int k;
      k = 0;
      while (sb.size() != 0 && k < 100) begin
        @(posedge clk);
        k++;
      end
    end
    chk("drain", sb.size(), 32'd0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Pipelined FP32 to signed int32 converter on the FPU result path.
- Consumes the integral-valued floats produced by the floor unit, and raw FP32 operands for the ftoi/round instructions.
- Supports three rounding modes and saturates out-of-range values and NaN.
- Two register stages with a valid/ready handshake so the FPU writeback arbiter can stall it.

Parameters:
- FTZ, 1, 1 = exponent-zero inputs (zero/denormal) are treated as ±0. 0 is not supported; a simulation assertion fires at elaboration if it is set.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- x  in  32  FP32 operand.
- mode  in  2  rounding mode: 0 = truncate toward zero, 1 = nearest-even, 2 = floor (toward -inf), 3 = treated as 0.
- in_valid  in  1  operand valid.
- in_ready  out  1  block accepts the operand this cycle.
- y  out  32  signed int32 result.
- flags  out  2  {invalid, inexact}.
- out_valid  out  1  y/flags valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset:
  - v1, v2, out_valid = 0; y, flags = 0.
  - Data registers are cleared.
  - in_ready = 1 on the first cycle after reset.
- Handshake:
  - adv2 = ~v2 | out_ready.
  - adv1 = ~v1 | adv2.
  - in_ready = adv1 (combinational from out_ready; no skid buffer).
  - Operand accepted on in_valid & in_ready.
  - Stage 1 moves into stage 2 when v1 & adv2.
  - out_valid = v2. y/flags are held stable while out_valid & ~out_ready.
  - Latency: 2 cycles from acceptance to out_valid with no stall. Throughput 1/cycle.
  - Results leave in acceptance order. No drop, no duplication.
- Stage 1 (decode/align), with s = x[31], e = x[30:23], f = x[22:0], sig = {1, f}:
  - e = 255, f ≠ 0 → NaN class.
  - e ≥ 158 → overflow class, except s = 1, e = 158, f = 0, which is exactly -2^31 and valid.
  - e = 0 → zero class. FTZ: denormals are inexact = 0 and give result 0 in all modes.
  - e < 127 → int_mag = 0; guard = (e = 126); sticky = (e < 126) | (f ≠ 0 when e = 126).
  - 127 ≤ e < 150 → int_mag = sig >> (150 - e); guard = the next bit below; sticky = OR of the remaining lower bits.
  - 150 ≤ e < 158 → int_mag = sig << (e - 150); guard = sticky = 0.
  - Stage register holds: s, class, int_mag[31:0], guard, sticky, mode.
- Stage 2 (round/negate/saturate):
  - inexact = guard | sticky.
  - inc is:
    - mode 0 → 0.
    - mode 1 → guard & (sticky | int_mag[0]).
    - mode 2 → s & inexact.
  - mag = int_mag + inc, computed 33 bits wide.
  - y = s ? -mag : mag.
  - Positive mag > 2^31-1, or negative mag > 2^31 → overflow.
- Special cases:
  - NaN → y = 0x7FFFFFFF, flags = 2'b10.
  - Overflow, positive → 0x7FFFFFFF, flags = 2'b10.
  - Overflow, negative (including -inf) → 0x80000000, flags = 2'b10.
  - +inf → 0x7FFFFFFF, flags = 2'b10.
  - Zero class → y = 0, flags = 0. -0 → 0.
  - Flags are zero whenever y is a valid result with inexact = 0.
- Reset mid-operation: in-flight operands are discarded. No out_valid after rst deasserts until a new operand completes.
- Simultaneous events: with stage 2 full, out_ready = 1 and in_valid = 1, the block accepts one, shifts one and emits one in the same cycle.

Test Plan:
- Mode 1 stream of 0x40200000 (2.5), 0x40600000 (3.5), 0x3F000000 (0.5), 0x3F400000 (0.75), one per cycle with out_ready = 1 → y = 2, 4, 0, 1 on consecutive cycles starting 2 cycles after the first accept; flags = 01 each.
- 0xBFC00000 (-1.5) in modes 0, 2, 1 → y = 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFE; flags = 01 each.
- 0x4F000000 (2^31) → 0x7FFFFFFF, flags 10. 0xCF000000 (-2^31) → 0x80000000, flags 00. 0x7FC00000 (NaN) → 0x7FFFFFFF, flags 10. 0x80000001 (denormal) → 0, flags 00.
- Integral floor-unit outputs in mode 0: 0x4B7FFFFF (16777215.0) → 0x00FFFFFF; 0xC1200000 (-10.0) → 0xFFFFFFF6; flags 00.
- Backpressure:
  - Stimulus: 5 back-to-back operands 1.0..5.0; out_ready held low for 4 cycles after the first out_valid.
  - Required: in_ready drops once both stages are full; y held at 1 while stalled; results then emerge in order 1..5 with no gaps once out_ready = 1.
- Reset mid-op: rst asserted for 1 cycle while both stages are valid → out_valid = 0 the next cycle, in_ready = 1, and no stale result appears afterwards.
